// File: rtl/linear_interp_pkg.sv
// linear_interp_pkg: shared definitions for the linear interpolating upsampler.
//   state_t     : segment FSM states (EMPTY, WAIT, EMIT, TAIL)
//   delta_width : width of the signed difference between two samples
//   acc_width   : width of the signed interpolation accumulator
package linear_interp_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    EMIT,
    TAIL
  } state_t;

  // One extra bit so that (new - old) of two unsigned samples is representable.
  function automatic int delta_width(input int width);
    return width + 1;
  endfunction

  // Holds prev*F plus up to (F-1) signed deltas, plus a sign bit.
  function automatic int acc_width(input int width, input int log2_factor);
    return width + log2_factor + 1;
  endfunction

endpackage

// File: rtl/linear_interp.sv
// linear_interp: streaming linear-interpolating upsampler.
// Every accepted input sample closes a segment [prev, nxt]; the block emits
// F = 2^LOG2_FACTOR samples floor(prev + k*(nxt-prev)/F), k = 0..F-1, and after
// the sample flagged in_last it emits that final sample once more.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data sample, in_last end of stream
//   out_valid/out_ready : output handshake, out_data interpolated sample
module linear_interp #(
  parameter int WIDTH       = 8,
  parameter int LOG2_FACTOR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  import linear_interp_pkg::*;

  localparam int F       = 1 << LOG2_FACTOR;
  localparam int DELTA_W = delta_width(WIDTH);
  localparam int ACC_W   = acc_width(WIDTH, LOG2_FACTOR);
  // One extra bit keeps k non-zero-width when LOG2_FACTOR is 0.
  localparam int K_W     = LOG2_FACTOR + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(F - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]          prev;
  logic [WIDTH-1:0]          nxt_sample;
  logic signed [DELTA_W-1:0] delta;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   delta_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic [K_W-1:0]            k;
  logic                      last_flag;
  logic                      in_fire;
  logic                      out_fire;
  logic                      k_at_end;

  // in_ready depends on state only, so there is no path from out_ready.
  assign in_ready  = (state == EMPTY) || (state == WAIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign k_at_end  = (k == K_LAST);
  assign delta_ext = ACC_W'(delta);
  assign acc_next  = acc + delta_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_fire) state_nxt = in_last ? TAIL : WAIT;
      WAIT:  if (in_fire) state_nxt = EMIT;
      EMIT:  if (out_fire && k_at_end) state_nxt = last_flag ? TAIL : WAIT;
      TAIL:  if (out_fire) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // The accumulator tracks prev*F + k*delta; since every output lies between
  // prev and nxt it is never negative, so dropping the low LOG2_FACTOR bits
  // is an exact floor division by F.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      k          <= '0;
      acc        <= '0;
      prev       <= '0;
      delta      <= '0;
      nxt_sample <= '0;
      last_flag  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            prev <= in_data;
            if (in_last) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
            end
          end
        end
        WAIT: begin
          if (in_fire) begin
            delta      <= $signed({1'b0, in_data}) - $signed({1'b0, prev});
            acc        <= ACC_W'($signed({1'b0, prev})) <<< LOG2_FACTOR;
            k          <= '0;
            last_flag  <= in_last;
            nxt_sample <= in_data;
            out_valid  <= 1'b1;
            out_data   <= prev;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (!k_at_end) begin
              k        <= k + 1'b1;
              acc      <= acc_next;
              out_data <= WIDTH'(acc_next >>> LOG2_FACTOR);
            end else if (last_flag) begin
              out_data <= nxt_sample;
            end else begin
              prev      <= nxt_sample;
              out_valid <= 1'b0;
            end
          end
        end
        TAIL: begin
          if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_interp.sv
// tb_linear_interp: directed self-checking bench for linear_interp.
// dut0 runs with F=4, dut1 with F=1; both share clk and rst.
module tb_linear_interp;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid0, in_ready0, in_last0, out_valid0, out_ready0;
  logic [7:0] in_data0, out_data0;
  logic       in_valid1, in_ready1, in_last1, out_valid1, out_ready1;
  logic [7:0] in_data1, out_data1;

  int errors = 0;
  int checks = 0;
  bit bp_mode = 1'b0;
  int mon_q0[$];
  int mon_q1[$];
  int exp_q[$];
  bit hold_pending = 1'b0;
  logic [7:0] held_data;

  linear_interp #(.WIDTH(8), .LOG2_FACTOR(2)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_last(in_last0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0)
  );

  linear_interp #(.WIDTH(8), .LOG2_FACTOR(0)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? mon_q0.size() : mon_q1.size();
  endfunction

  function automatic int qget(input int sel, input int idx);
    return (sel == 0) ? mon_q0[idx] : mon_q1[idx];
  endfunction

  // Offer one sample and hold it until the DUT accepts it (bounded wait).
  task automatic applyStimulus(input int sel, input logic [7:0] d, input logic last);
    int waited;
    bit accepted;
    logic rdy;
    @(negedge clk);
    if (sel == 0) begin
      in_valid0 = 1'b1; in_data0 = d; in_last0 = last;
    end else begin
      in_valid1 = 1'b1; in_data1 = d; in_last1 = last;
    end
    waited = 0;
    accepted = 1'b0;
    while (!accepted && waited < 300) begin
      rdy = (sel == 0) ? in_ready0 : in_ready1;
      if (rdy) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput($sformatf("accept_%0d", d), 32'(accepted), 32'd1);
    @(negedge clk);
    if (sel == 0) in_valid0 = 1'b0;
    else          in_valid1 = 1'b0;
  endtask

  // Wait for the expected number of beats, then compare them and the idle state.
  task automatic checkStream(input int sel, input string tag);
    int waited;
    waited = 0;
    while (qsize(sel) < exp_q.size() && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, "_count"}, 32'(qsize(sel)), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < qsize(sel))
        checkOutput($sformatf("%s_beat%0d", tag, i), 32'(qget(sel, i)), 32'(exp_q[i]));
    end
    checkOutput({tag, "_idle_in_ready"}, 32'((sel == 0) ? in_ready0 : in_ready1), 32'd1);
    checkOutput({tag, "_idle_out_valid"}, 32'((sel == 0) ? out_valid0 : out_valid1), 32'd0);
    if (sel == 0) mon_q0.delete();
    else          mon_q1.delete();
  endtask

  // Collect accepted beats and watch hold-stability and in_ready during output.
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid0 && out_ready0) mon_q0.push_back(int'(out_data0));
      if (out_valid1 && out_ready1) mon_q1.push_back(int'(out_data1));
      if (out_valid0) checkOutput("in_ready_low_while_emitting", 32'(in_ready0), 32'd0);
      if (hold_pending) checkOutput("out_data_held_stable", 32'(out_data0), 32'(held_data));
      hold_pending = out_valid0 && !out_ready0;
      held_data = out_data0;
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    out_ready0 = 1'b1;
    forever begin
      @(negedge clk);
      out_ready0 = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; in_last0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; in_last1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid0", 32'(out_valid0), 32'd0);
    checkOutput("reset_out_data0", 32'(out_data0), 32'd0);
    checkOutput("reset_out_valid1", 32'(out_valid1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready0", 32'(in_ready0), 32'd1);
    checkOutput("reset_in_ready1", 32'(in_ready1), 32'd1);

    $display("[TB] ramp 0,8,16");
    applyStimulus(0, 8'd0, 1'b0);
    applyStimulus(0, 8'd8, 1'b0);
    applyStimulus(0, 8'd16, 1'b1);
    exp_q = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    checkStream(0, "ramp");

    $display("[TB] descending 10,2");
    applyStimulus(0, 8'd10, 1'b0);
    applyStimulus(0, 8'd2, 1'b1);
    exp_q = '{10, 8, 6, 4, 2};
    checkStream(0, "desc");

    $display("[TB] floor 0,3");
    applyStimulus(0, 8'd0, 1'b0);
    applyStimulus(0, 8'd3, 1'b1);
    exp_q = '{0, 0, 1, 2, 3};
    checkStream(0, "floor");

    $display("[TB] extremes 255,0,255");
    applyStimulus(0, 8'd255, 1'b0);
    applyStimulus(0, 8'd0, 1'b0);
    applyStimulus(0, 8'd255, 1'b1);
    exp_q = '{255, 191, 127, 63, 0, 63, 127, 191, 255};
    checkStream(0, "extremes");

    $display("[TB] backpressure ramp");
    bp_mode = 1'b1;
    applyStimulus(0, 8'd0, 1'b0);
    applyStimulus(0, 8'd8, 1'b0);
    applyStimulus(0, 8'd16, 1'b1);
    exp_q = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    checkStream(0, "bp_ramp");
    bp_mode = 1'b0;
    @(negedge clk);

    $display("[TB] single sample 77");
    applyStimulus(0, 8'd77, 1'b1);
    exp_q = '{77};
    checkStream(0, "single");

    $display("[TB] F=1 stream 5,9");
    applyStimulus(1, 8'd5, 1'b0);
    applyStimulus(1, 8'd9, 1'b1);
    exp_q = '{5, 9};
    checkStream(1, "f1");

    $display("[TB] reset mid-segment");
    applyStimulus(0, 8'd0, 1'b0);
    applyStimulus(0, 8'd16, 1'b0);
    waited = 0;
    while (mon_q0.size() < 2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("mid_reset_two_beats_seen", 32'(mon_q0.size() >= 2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset_out_valid", 32'(out_valid0), 32'd0);
    checkOutput("mid_reset_out_data", 32'(out_data0), 32'd0);
    checkOutput("mid_reset_in_ready", 32'(in_ready0), 32'd1);
    mon_q0.delete();
    applyStimulus(0, 8'd4, 1'b0);
    applyStimulus(0, 8'd8, 1'b1);
    exp_q = '{4, 5, 6, 7, 8};
    checkStream(0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linear_interp.md
Name: linear_interp

Overview:
- Streaming upsampler, the reconstruction-side counterpart of the windowed-mean block. The mean block decimates a sample stream to an average; this block expands a decimated stream back to full rate.
- Each accepted input sample closes a segment. The block emits 2^LOG2_FACTOR linearly interpolated output samples per segment.
- Placement: between a low-rate producer and a full-rate consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8, bit width of input and output samples (unsigned).
- LOG2_FACTOR, 2, log2 of the upsampling factor F = 2^LOG2_FACTOR. Legal range is 0..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample offered.
- in_ready  output  1  block can accept an input sample this cycle.
- in_data  input  WIDTH  input sample.
- in_last  input  1  accepted sample is the last one of the stream.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  interpolated sample.

Behaviour:
- Reset: one clock is synchronous and the reset is active-high. While rst is high at a clock edge:
  - state becomes EMPTY, out_valid=0, out_data=0, k=0, acc=0, prev=0.
  - in_ready=1 in the following cycle.
  - Reset mid-segment discards all pending outputs; there is no partial flush.
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready is a registered/state-decoded signal: it is 1 in EMPTY and WAIT, 0 in EMIT and TAIL. It has no combinational path from out_ready.
- out_data and out_valid are registered. While out_valid=1 and out_ready=0, out_data holds stable.
- State EMPTY (no previous sample):
  - in_fire: prev <= in_data.
  - If in_last=1, go TAIL with out_data=in_data; otherwise go WAIT.
- State WAIT (previous sample held):
  - in_fire: delta <= in_data - prev, as a signed value of WIDTH+1 bits.
  - acc <= prev << LOG2_FACTOR, with width WIDTH+LOG2_FACTOR+1, signed.
  - k <= 0, lastflag <= in_last, nxt <= in_data.
  - out_valid=1 and out_data=prev from the next cycle; go EMIT.
  - Latency from in_fire to first out_valid is 1 cycle.
- State EMIT: out_data = acc >> LOG2_FACTOR (arithmetic shift, i.e. floor). The value is exact: floor((prev*F + k*(nxt-prev))/F).
  - out_fire with k < F-1: k <= k+1, acc <= acc + delta, out_data updated next cycle, so back-to-back beats need no bubble.
  - out_fire with k == F-1 and lastflag=0: prev <= nxt, out_valid <= 0, go WAIT.
  - out_fire with k == F-1 and lastflag=1: out_data <= nxt, stay valid, go TAIL.
- State TAIL (emit the final sample once):
  - out_fire: out_valid <= 0, go EMPTY.
- Throughput: F output beats plus 1 input-accept cycle per segment. That is F/(F+1) of full rate; this is acceptable.
- Output values are always within [min(prev,nxt), max(prev,nxt)], so no overflow or saturation is needed.
- LOG2_FACTOR=0:
  - F=1; each segment emits only prev.
  - The stream passes through delayed by one sample, and the final sample is emitted via TAIL.
- in_last while in EMPTY (single-sample stream): exactly one output, equal to that sample.
- in_valid while in EMIT/TAIL is ignored (in_ready=0). The producer holds the sample.

Decomposition:
- Shared math package holds:
  - state enum {EMPTY, WAIT, EMIT, TAIL};
  - localparams F = 1 << LOG2_FACTOR and ACC_W = WIDTH+LOG2_FACTOR+1;
  - the delta/acc width helper.
- No sub-module: the accumulator and FSM are small enough to be a single module, about 150-200 lines.

Test Plan:
- WIDTH=8, F=4, inputs 0, 8, 16(last), out_ready=1 -> outputs 0,2,4,6,8,10,12,14,16, then idle in EMPTY with in_ready=1.
- Descending and rounding: inputs 10, 2(last) -> 10,8,6,4,2. Inputs 0, 3(last) -> 0,0,1,2,3 (floor).
- Extremes: inputs 255, 0, 255(last) -> 255,191,127,63,0,63,127,191,255. No wrap.
- Backpressure: toggle out_ready randomly in scenario 1 -> identical sequence. out_data stable whenever out_valid=1 and out_ready=0. in_ready=0 throughout EMIT/TAIL.
- Single sample: input 77 with in_last -> exactly one output 77. LOG2_FACTOR=0 with inputs 5, 9(last) -> 5, 9.
- Reset mid-EMIT: assert rst after 2 beats of a segment -> next cycle out_valid=0, out_data=0, in_ready=1. A fresh stream 4, 8(last) then yields 4,5,6,7,8.
